// File: rtl/slice_loopback_pkg.sv
// Shared FSM encoding and slice-count helpers for the split/rejoin loopback.
// Also used by the bench so both sides derive NSLICE identically.
package slice_loopback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    function automatic int nslice(input int width, input int slice);
        return width / slice;
    endfunction

    function automatic bit params_ok(input int width, input int slice);
        return ((width % slice) == 0) && ((width / slice) >= 2);
    endfunction

endpackage

// File: rtl/slice_joiner.sv
// Reassembly register: writes one SLICE-wide chunk per cycle at the given slice position.
// Latency: written chunk visible on word_o the cycle after wr_en_i; no backpressure.
module slice_joiner
    import slice_loopback_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic                                    clk,
    input  logic                                    clr_i,
    input  logic                                    wr_en_i,
    input  logic [$clog2(nslice(WIDTH, SLICE))-1:0] pos_i,
    input  logic [SLICE-1:0]                        slice_i,
    output logic [WIDTH-1:0]                        word_o
);

    logic [WIDTH-1:0] word_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            word_q <= '0;
        end else if (wr_en_i) begin
            word_q[int'(pos_i)*SLICE +: SLICE] <= slice_i;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/slice_loopback.sv
// Splits an accepted word into NSLICE slices, rejoins them and compares against the original.
// Latency: slices T+1..T+NSLICE, result T+NSLICE+1; in_ready only in IDLE, outputs never stall.
module slice_loopback
    import slice_loopback_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SLICE     = 4,
    parameter int MSB_FIRST = 0,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             inject,
    output logic             slice_valid,
    output logic [SLICE-1:0] slice_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_equal,
    output logic [ERR_W-1:0] err_count
);

    localparam int NSLICE = nslice(WIDTH, SLICE);
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (!params_ok(WIDTH, SLICE)) begin : g_bad_params
        $error("slice_loopback: WIDTH must be a multiple of SLICE with at least two slices");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] out_data_q;
    logic             out_equal_q;
    logic [ERR_W-1:0] err_q;

    logic             accept;
    logic [IDX_W-1:0] pos;
    logic [SLICE-1:0] slice_cur;
    logic [SLICE-1:0] slice_join;
    logic [WIDTH-1:0] asm_word;
    logic             words_eq;
    logic             in_check;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    idx_d   = '0;
                    state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_equal_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            if (in_check) begin
                out_data_q  <= asm_word;
                out_equal_q <= words_eq;
                if (!words_eq && (err_q != {ERR_W{1'b1}})) begin
                    err_q <= err_q + 1'b1;
                end
            end
        end
    end

    // Slice order only changes which position is read; the joiner writes back to that same position.
    assign pos       = (MSB_FIRST != 0) ? (LAST_IDX - idx_q) : idx_q;
    assign slice_cur = hold_q[int'(pos)*SLICE +: SLICE];

    always_comb begin
        slice_join    = slice_cur;
        slice_join[0] = slice_cur[0] ^ inject;
    end

    assign accept = (state_q == ST_IDLE) && in_valid && !rst;

    slice_joiner #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) u_joiner (
        .clk     (clk),
        .clr_i   (rst || accept),
        .wr_en_i (slice_valid),
        .pos_i   (pos),
        .slice_i (slice_join),
        .word_o  (asm_word)
    );

    // A reset landing in CHECK suppresses the result pulse for the aborted word.
    assign in_check    = (state_q == ST_CHECK) && !rst;
    assign words_eq    = (asm_word == hold_q);

    assign in_ready    = (state_q == ST_IDLE);
    assign slice_valid = (state_q == ST_SPLIT);
    assign slice_data  = slice_valid ? slice_cur : '0;
    assign out_valid   = in_check;
    assign out_data    = in_check ? asm_word : out_data_q;
    assign out_equal   = in_check ? words_eq : out_equal_q;
    assign err_count   = err_q;

endmodule
